// File: rtl/layer_pipeline.sv
// layer_pipeline: 640x480 VGA timing with NUM_LAYERS scrolled texel layers composited bottom-up; macro LAYER_PIPELINE_VBLANK_COMMIT_EN defers cfg commits to vblank start.
// Latency: layer_addr 1 pixel tick after the h/v counter value, VGA_* 2 ticks after it; layer_data is expected 1 clock after layer_addr.
// Backpressure: cfg_ready drops while the single pending cfg slot is occupied; out-of-range writes are rejected with a cfg_err pulse.
module layer_pipeline #(
  parameter int NUM_LAYERS  = 2,
  parameter int ADDR_W      = 15,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_DIV     = 4
) (
  input  logic                         CLK100MHZ,
  input  logic                         CPU_RESETN,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic [3:0]                   VGA_R,
  output logic [3:0]                   VGA_G,
  output logic [3:0]                   VGA_B,
  output logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [NUM_LAYERS*13-1:0]     layer_data,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [2:0]                   cfg_layer,
  input  logic [7:0]                   cfg_hoff,
  input  logic [7:0]                   cfg_voff,
  input  logic                         cfg_en,
  output logic                         cfg_err,
  output logic                         frame_start
);
  localparam int DIV_W = $clog2(PIX_DIV);

  logic [DIV_W-1:0]              div;
  logic                          tick;
  logic [9:0]                    h, v;
  logic [7:0]                    hoff_q [NUM_LAYERS];
  logic [7:0]                    voff_q [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]         en_q;
  logic                          pend_vld, pend_en;
  logic [2:0]                    pend_layer;
  logic [7:0]                    pend_hoff, pend_voff;
  logic                          act1, hsy1, vsy1;
  logic [NUM_LAYERS*ADDR_W-1:0]  addr_nxt;
  logic [ADDR_W-1:0]             xa, ya;
  logic [11:0]                   col;
  logic                          cfg_bad, commit;

  assign tick = (div == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (h == 10'd799) begin
          h <= '0;
          v <= (v == 10'd524) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  // Scrolled texel coordinates wrap with a single subtract; offsets are always < image size.
  always_comb begin
    addr_nxt = '0;
    xa       = '0;
    ya       = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      xa = ADDR_W'(h >> SCALE_SHIFT) + ADDR_W'(hoff_q[i]);
      if (xa >= ADDR_W'(IMG_W)) xa = xa - ADDR_W'(IMG_W);
      ya = ADDR_W'(v >> SCALE_SHIFT) + ADDR_W'(voff_q[i]);
      if (ya >= ADDR_W'(IMG_H)) ya = ya - ADDR_W'(IMG_H);
      addr_nxt[i*ADDR_W +: ADDR_W] = ya * ADDR_W'(IMG_W) + xa;
    end
  end

  always_comb begin
    col = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (en_q[i] && layer_data[i*13]) col = layer_data[i*13+1 +: 12];
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      layer_addr  <= '0;
      act1        <= 1'b0;
      hsy1        <= 1'b0;
      vsy1        <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h == 10'd0) && (v == 10'd0);
      if (tick) begin
        layer_addr <= addr_nxt;
        act1       <= (h < 10'd640) && (v < 10'd480);
        hsy1       <= (h >= 10'd656) && (h <= 10'd751);
        vsy1       <= (v >= 10'd490) && (v <= 10'd491);
        VGA_HS     <= !hsy1;
        VGA_VS     <= !vsy1;
        VGA_R      <= act1 ? col[11:8] : 4'h0;
        VGA_G      <= act1 ? col[7:4]  : 4'h0;
        VGA_B      <= act1 ? col[3:0]  : 4'h0;
      end
    end
  end

  assign cfg_ready = !pend_vld;
  assign cfg_bad   = (int'(cfg_layer) >= NUM_LAYERS) || (int'(cfg_hoff) >= IMG_W) ||
                     (int'(cfg_voff) >= IMG_H);

`ifdef LAYER_PIPELINE_VBLANK_COMMIT_EN
  assign commit = pend_vld && tick && (h == 10'd0) && (v == 10'd480);
`else
  assign commit = pend_vld;
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cfg_err    <= 1'b0;
      pend_vld   <= 1'b0;
      pend_layer <= '0;
      pend_hoff  <= '0;
      pend_voff  <= '0;
      pend_en    <= 1'b0;
      en_q       <= '1;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        hoff_q[i] <= '0;
        voff_q[i] <= '0;
      end
    end else begin
      cfg_err <= cfg_valid && cfg_ready && cfg_bad;
      if (cfg_valid && cfg_ready && !cfg_bad) begin
        pend_vld   <= 1'b1;
        pend_layer <= cfg_layer;
        pend_hoff  <= cfg_hoff;
        pend_voff  <= cfg_voff;
        pend_en    <= cfg_en;
      end else if (commit) begin
        pend_vld <= 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (pend_layer == 3'(i)) begin
            hoff_q[i] <= pend_hoff;
            voff_q[i] <= pend_voff;
            en_q[i]   <= pend_en;
          end
        end
      end
    end
  end
endmodule
